audio_dac_mc: RTL and testbench
===============================

Name: audio_dac_mc

Overview:
- Parametrised multi-channel sigma-delta audio DAC. Generalises the fixed 6-bit, single-channel, first-order dac.
- Turns N parallel PCM samples into N 1-bit pulse-density streams that drive the board audio pins (AUDIO_L/AUDIO_R and any future channels).
- Adds a selectable modulator order, signed or unsigned input, strobed sample latching and mute-to-midscale.
- Sits between the core's audio mixer (for example the emsx pDac_SL/pDac_SR outputs) and the FPGA output pins.

Parameters:
- CHANNELS, 2, number of independent channels (1..8).
- WIDTH, 16, sample width in bits (4..24).
- ORDER, 1, modulator order: 1 = first-order accumulator, 2 = second-order error-feedback.
- SIGNED_IN, 0, 1 = two's-complement input samples, 0 = offset-binary input samples.

Ports:
- clk_sys, input, 1, system clock; the modulators run at this rate.
- reset, input, 1, asynchronous, active-high reset.
- ce_sample, input, 1, sample strobe; audio_in is latched on cycles where it is high.
- mute, input, 1, forces midscale at the next ce_sample.
- audio_in, input, CHANNELS*WIDTH, packed samples; channel k occupies bits [k*WIDTH +: WIDTH].
- dac_out, output, CHANNELS, registered 1-bit pulse-density outputs.
- sat, output, CHANNELS, sticky flag: the channel's second-order integrator saturated; cleared on reset only.

Behaviour:
- Clock and reset: one clock (clk_sys); reset is asynchronous and active-high.
- Reset values:
  - dac_out = 0, sat = 0.
  - Latched sample s = midscale (2^(WIDTH-1)).
  - All integrators and accumulators = 0.
  - Reset asserted mid-stream returns every register to these values immediately, regardless of ce_sample.
- Input conversion:
  - SIGNED_IN=1: u = audio_in slice with MSB inverted.
  - SIGNED_IN=0: u = the slice as given.
- Sample latch (per channel):
  - On a cycle with ce_sample=1: s <= mute ? midscale : u.
  - Otherwise s holds.
  - The new s is used by the modulator from the next cycle on (one-cycle input latency).
  - mute asserted or deasserted without ce_sample has no effect until the next ce_sample.
  - ce_sample held high continuously means the input is sampled every cycle.
- ORDER=1:
  - acc is unsigned, WIDTH+1 bits.
  - Every cycle: acc <= {1'b0, acc[WIDTH-1:0]} + s, and dac_out <= carry (bit WIDTH of the new sum).
  - Average density of dac_out equals s / 2^WIDTH exactly over a 2^WIDTH-cycle window.
- ORDER=2:
  - i1 and i2 are signed, WIDTH+4 bits.
  - Feedback y = dac_out ? (2^WIDTH - 1) : 0.
  - Every cycle: i1' = i1 + s - y, and i2' = i2 + i1' - y.
  - dac_out <= ~i2'[MSB], i.e. output 1 when i2' >= 0.
  - Both integrators saturate to the range [-2^(WIDTH+2), 2^(WIDTH+2) - 1].
  - Any clamp event sets sat[k]=1; sat is tied to 0 when ORDER=1.
- Width rules:
  - All sums are computed at full width, with no truncation before the carry/sign decision.
  - s = 0 yields dac_out constantly 0.
  - s = 2^WIDTH - 1 yields exactly one 0 per 2^WIDTH cycles (ORDER=1).
- Channels:
  - Channels are fully independent and share only clk_sys, reset, ce_sample and mute.
- Output latency:
  - dac_out changes only on clk_sys edges and is glitch-free: driven directly from a flop.

Decomposition:
- Package audio_dac_pkg holds:
  - the order enum (ORD1, ORD2);
  - function midscale(WIDTH);
  - function sat_lim(WIDTH), returning 2^(WIDTH+2).
- Sub-module audio_dac_chan: one channel (sample latch plus modulator, ORDER and SIGNED_IN as parameters).
- audio_dac_mc is a generate loop over CHANNELS instances of audio_dac_chan.

Test Plan:
- Reset behaviour. Setup: WIDTH=6, ORDER=1. Stimulus: assert reset mid-stream with audio_in=6'd40. Required: dac_out=0 asynchronously; after release, the first pattern is that of midscale 32 (0,1,0,1...) until the next ce_sample.
- Midscale pattern. Setup: WIDTH=6, ORDER=1, SIGNED_IN=0. Stimulus: ce_sample pulse with 6'd32. Required: from 2 cycles after the pulse, dac_out alternates 0,1,0,1; density is exactly 32/64 over 64 cycles.
- Rail values. Setup: WIDTH=6, ORDER=1. Stimulus: input 0. Required: dac_out=0 forever. Stimulus: input 63. Required: exactly 63 ones per 64-cycle window.
- Signed conversion. Setup: SIGNED_IN=1, WIDTH=6. Stimulus: input 6'b100000 (-32). Required: constant 0. Stimulus: input 6'b011111 (+31). Required: 63/64 density.
- Mute timing. Setup: CHANNELS=2. Stimulus: ch0=10, ch1=50, then assert mute with no ce_sample. Required: densities stay 10/64 and 50/64. Stimulus: next ce_sample. Required: both channels switch to 32/64.
- Second-order saturation. Setup: ORDER=2, WIDTH=8. Stimulus: ramp the input 0 to 255 over 4096 cycles. Required: the 256-cycle moving-average density is within ±2/256 of input/256, and sat stays 0. Stimulus: force i1 near its limit via a step from 0 to 255 held for 10^5 cycles. Required: no wrap (dac_out density at least 254/256), and sat records any clamp.

Source files
------------

// File: rtl/audio_dac_pkg.sv
// Shared definitions for the multi-channel sigma-delta audio DAC.
//   order_e  : modulator order selector (first-order accumulator or
//              second-order error-feedback loop)
//   midscale : code that produces a 50 % pulse density for a given width
//   sat_lim  : magnitude of the second-order integrator clamp, 2^(width+2)
package audio_dac_pkg;

  typedef enum logic [1:0] {
    ORD1 = 2'd1,
    ORD2 = 2'd2
  } order_e;

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  function automatic int unsigned sat_lim(input int unsigned width);
    return 32'd1 << (width + 32'd2);
  endfunction

endpackage

// File: rtl/audio_dac_chan.sv
// One DAC channel: sample latch plus first- or second-order sigma-delta
// modulator producing a 1-bit pulse-density stream.
// Ports:
//   clk_sys   : modulator clock
//   reset     : asynchronous active-high reset
//   ce_sample : latch sample_in (or midscale when muted) on this cycle
//   mute      : select midscale at the next ce_sample
//   sample_in : raw sample, offset-binary or two's complement per SIGNED_IN
//   dac_out   : registered pulse-density output
//   sat       : sticky second-order integrator clamp flag (0 for ORDER=1)
module audio_dac_chan
  import audio_dac_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ORDER     = 1,
  parameter int SIGNED_IN = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_sample,
  input  logic             mute,
  input  logic [WIDTH-1:0] sample_in,
  output logic             dac_out,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

  logic [WIDTH-1:0] conv_s;
  logic [WIDTH-1:0] sample_r;
  logic             dac_r;
  logic             sat_r;

  // Map the input to offset binary: inverting the MSB turns two's complement into offset binary.
  always_comb begin
    conv_s = sample_in;
    if (SIGNED_IN != 0) begin
      conv_s = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
    end else begin
      conv_s = sample_in;
    end
  end

  // Sample latch: mute only takes effect when a new sample is strobed in.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sample_r <= MID;
    end else if (ce_sample) begin
      sample_r <= mute ? MID : conv_s;
    end else begin
      sample_r <= sample_r;
    end
  end

  if (ORDER == int'(ORD2)) begin : g_ord2
    localparam int IW = WIDTH + 4;
    localparam int SW = WIDTH + 6;
    localparam logic signed [SW-1:0] LIM_HI = SW'(sat_lim(WIDTH) - 32'd1);
    // -2^(W+2) is the bitwise complement of 2^(W+2)-1.
    localparam logic signed [SW-1:0] LIM_LO = ~LIM_HI;
    localparam logic signed [SW-1:0] FB     = SW'((32'd1 << WIDTH) - 32'd1);

    logic signed [IW-1:0] i1_r;
    logic signed [IW-1:0] i2_r;
    logic signed [SW-1:0] s_ext_s;
    logic signed [SW-1:0] y_s;
    logic signed [SW-1:0] i1_sum_s;
    logic signed [SW-1:0] i2_sum_s;
    logic signed [SW-1:0] i1_nxt_s;
    logic signed [SW-1:0] i2_nxt_s;
    logic                 clamp1_s;
    logic                 clamp2_s;

    // Two error-feedback integrators, each summed at full width and then clamped.
    always_comb begin
      s_ext_s  = {6'd0, sample_r};
      y_s      = dac_r ? FB : {SW{1'b0}};
      i1_sum_s = {{2{i1_r[IW-1]}}, i1_r} + s_ext_s - y_s;
      clamp1_s = 1'b0;
      if (i1_sum_s > LIM_HI) begin
        i1_nxt_s = LIM_HI;
        clamp1_s = 1'b1;
      end else if (i1_sum_s < LIM_LO) begin
        i1_nxt_s = LIM_LO;
        clamp1_s = 1'b1;
      end else begin
        i1_nxt_s = i1_sum_s;
      end
      i2_sum_s = {{2{i2_r[IW-1]}}, i2_r} + i1_nxt_s - y_s;
      clamp2_s = 1'b0;
      if (i2_sum_s > LIM_HI) begin
        i2_nxt_s = LIM_HI;
        clamp2_s = 1'b1;
      end else if (i2_sum_s < LIM_LO) begin
        i2_nxt_s = LIM_LO;
        clamp2_s = 1'b1;
      end else begin
        i2_nxt_s = i2_sum_s;
      end
    end

    // Integrator state, sign-decided output bit and sticky clamp flag.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        i1_r  <= {IW{1'b0}};
        i2_r  <= {IW{1'b0}};
        dac_r <= 1'b0;
        sat_r <= 1'b0;
      end else begin
        i1_r  <= i1_nxt_s[IW-1:0];
        i2_r  <= i2_nxt_s[IW-1:0];
        dac_r <= ~i2_nxt_s[SW-1];
        sat_r <= sat_r | clamp1_s | clamp2_s;
      end
    end
  end else begin : g_ord1
    // Only the low WIDTH bits of the accumulator are kept; its carry bit is dac_r itself.
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH:0]   acc_sum_s;

    // Accumulator sum with room for the carry that becomes the output bit.
    always_comb begin
      acc_sum_s = {1'b0, acc_r} + {1'b0, sample_r};
    end

    // Accumulator and carry output; the saturation flag cannot set in this order.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        acc_r <= {WIDTH{1'b0}};
        dac_r <= 1'b0;
        sat_r <= 1'b0;
      end else begin
        acc_r <= acc_sum_s[WIDTH-1:0];
        dac_r <= acc_sum_s[WIDTH];
        sat_r <= 1'b0;
      end
    end
  end

  assign dac_out = dac_r;
  assign sat     = sat_r;

endmodule

// File: rtl/audio_dac_mc.sv
// Multi-channel sigma-delta audio DAC: CHANNELS independent modulators sharing
// clock, reset, sample strobe and mute.
// Ports:
//   clk_sys   : modulator clock
//   reset     : asynchronous active-high reset
//   ce_sample : sample strobe for all channels
//   mute      : force midscale at the next ce_sample
//   audio_in  : packed samples, channel k at [k*WIDTH +: WIDTH]
//   dac_out   : registered 1-bit pulse-density output per channel
//   sat       : sticky second-order saturation flag per channel
module audio_dac_mc
  import audio_dac_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int ORDER     = 1,
  parameter int SIGNED_IN = 0
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce_sample,
  input  logic                      mute,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  output logic [CHANNELS-1:0]       dac_out,
  output logic [CHANNELS-1:0]       sat
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    audio_dac_chan #(
      .WIDTH    (WIDTH),
      .ORDER    (ORDER),
      .SIGNED_IN(SIGNED_IN)
    ) u_chan (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ce_sample(ce_sample),
      .mute     (mute),
      .sample_in(audio_in[k*WIDTH +: WIDTH]),
      .dac_out  (dac_out[k]),
      .sat      (sat[k])
    );
  end

endmodule

// File: tb/tb_audio_dac_mc.sv
module tb_audio_dac_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        mute;
  logic [11:0] au;
  logic [5:0]  as_in;
  logic [7:0]  a2;
  logic [1:0]  du, su;
  logic [0:0]  ds, ss, d2, s2;

  int tests = 0;
  int fails = 0;

  // reference model of the second-order loop (WIDTH=8)
  longint m_i1, m_i2, m_s;
  int     m_d, m_sat;
  int     mism;

  always #5 clk = ~clk;

  audio_dac_mc #(.CHANNELS(2), .WIDTH(6), .ORDER(1), .SIGNED_IN(0)) dut_u (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .mute(mute),
    .audio_in(au), .dac_out(du), .sat(su));

  audio_dac_mc #(.CHANNELS(1), .WIDTH(6), .ORDER(1), .SIGNED_IN(1)) dut_s (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .mute(mute),
    .audio_in(as_in), .dac_out(ds), .sat(ss));

  audio_dac_mc #(.CHANNELS(1), .WIDTH(8), .ORDER(2), .SIGNED_IN(0)) dut_2 (
    .clk_sys(clk), .reset(rst), .ce_sample(ce), .mute(mute),
    .audio_in(a2), .dac_out(d2), .sat(s2));

  typedef struct {
    logic [5:0] u0;
    logic [5:0] u1;
    logic [5:0] sv;
    logic       m;
    int         e0;
    int         e1;
    int         es;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ce();
    ce = 1'b1;
    step();
    ce = 1'b0;
  endtask

  task automatic count64(output int c0, output int c1, output int cs);
    c0 = 0; c1 = 0; cs = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      c0 += int'(du[0]);
      c1 += int'(du[1]);
      cs += int'(ds[0]);
    end
  endtask

  // one clock of the second-order reference, using the inputs present at the edge
  task automatic model_step(input int in_v);
    longint y, a, b;
    y = (m_d != 0) ? 64'sd255 : 64'sd0;
    a = m_i1 + m_s - y;
    if (a > 1023) begin a = 1023; m_sat = 1; end
    else if (a < -1024) begin a = -1024; m_sat = 1; end
    b = m_i2 + a - y;
    if (b > 1023) begin b = 1023; m_sat = 1; end
    else if (b < -1024) begin b = -1024; m_sat = 1; end
    m_i1 = a;
    m_i2 = b;
    m_d  = (b >= 0) ? 1 : 0;
    m_s  = longint'(in_v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, cs, found, ones;

    tbl[0] = '{6'd32, 6'd32, 6'b100000, 1'b0, 32, 32, 0};
    tbl[1] = '{6'd0,  6'd63, 6'b011111, 1'b0, 0,  63, 63};
    tbl[2] = '{6'd10, 6'd50, 6'b000000, 1'b0, 10, 50, 32};
    tbl[3] = '{6'd63, 6'd0,  6'b111111, 1'b0, 63, 0,  31};
    tbl[4] = '{6'd10, 6'd50, 6'b010101, 1'b1, 32, 32, 32};
    tbl[5] = '{6'd1,  6'd62, 6'b100001, 1'b0, 1,  62, 1};

    rst = 1'b1; ce = 1'b0; mute = 1'b0; au = 12'd0; as_in = 6'd0; a2 = 8'd0;
    step(); step();
    check("reset_outputs", int'({du, su, ds, ss, d2, s2}), 0);

    // release: latched sample is midscale, so 0,1,0,1,...
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("mid_pattern_u[%0d]", i), int'(du[0]), i % 2);
      check($sformatf("mid_pattern_s[%0d]", i), int'(ds[0]), i % 2);
    end

    // mid-stream reset while a 40 sample is playing
    au = {6'd40, 6'd40};
    pulse_ce();
    for (int i = 0; i < 10; i++) step();
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (du[0] == 1'b1) found = 1;
    end
    check("wait_for_one", found, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_dac", int'(du), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("post_reset_pattern[%0d]", i), int'(du[0]), i % 2);
    end

    // table-driven density vectors
    for (int v = 0; v < 6; v++) begin
      au = {tbl[v].u1, tbl[v].u0};
      as_in = tbl[v].sv;
      mute = tbl[v].m;
      pulse_ce();
      mute = 1'b0;
      step(); step(); step();
      count64(c0, c1, cs);
      check($sformatf("vec%0d_ch0", v), c0, tbl[v].e0);
      check($sformatf("vec%0d_ch1", v), c1, tbl[v].e1);
      check($sformatf("vec%0d_signed", v), cs, tbl[v].es);
    end

    // mute without a strobe has no effect; next strobe applies it
    au = {6'd50, 6'd10};
    pulse_ce();
    step(); step();
    mute = 1'b1;
    step(); step(); step();
    count64(c0, c1, cs);
    check("mute_noce_ch0", c0, 10);
    check("mute_noce_ch1", c1, 50);
    pulse_ce();
    step(); step(); step();
    count64(c0, c1, cs);
    check("mute_ce_ch0", c0, 32);
    check("mute_ce_ch1", c1, 32);
    mute = 1'b0;
    step(); step();
    count64(c0, c1, cs);
    check("unmute_noce_ch0", c0, 32);
    check("unmute_noce_ch1", c1, 32);
    pulse_ce();
    step(); step(); step();
    count64(c0, c1, cs);
    check("unmute_ce_ch0", c0, 10);
    check("unmute_ce_ch1", c1, 50);

    // second-order channel against the reference loop
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    m_i1 = 0; m_i2 = 0; m_s = 128; m_d = 0; m_sat = 0; mism = 0;
    ce = 1'b1;
    for (int c = 0; c < 4096; c++) begin
      a2 = 8'(c / 16);
      step();
      model_step(int'(a2));
      if (int'(d2[0]) != m_d) mism++;
    end
    check("ord2_ramp_bitexact", mism, 0);
    check("ord2_ramp_sat", int'(s2[0]), m_sat);

    a2 = 8'd0;
    for (int c = 0; c < 300; c++) begin
      step();
      model_step(int'(a2));
      if (int'(d2[0]) != m_d) mism++;
    end
    a2 = 8'd255;
    ones = 0;
    for (int c = 0; c < 2048; c++) begin
      step();
      model_step(int'(a2));
      if (int'(d2[0]) != m_d) mism++;
      if (c >= 2048 - 256) ones += int'(d2[0]);
    end
    ce = 1'b0;
    check("ord2_step_bitexact", mism, 0);
    check("ord2_step_density_ok", (ones >= 254) ? 1 : 0, 1);
    check("ord2_step_sat", int'(s2[0]), m_sat);
    check("ord1_sat_zero", int'({su, ss}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
